// File: rtl/controlador_memoria_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : controlador_memoria_pkg
//  Description : Shared state encoding and default widths for the
//                push-button RAM sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package controlador_memoria_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DATA_W = 8;

  // Sequencer state encoding; every 2-bit code is a named state
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_WRITE   = 2'b01;
  localparam logic [1:0] ST_RD_ADDR = 2'b10;
  localparam logic [1:0] ST_RD_CAP  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/controlador_memoria_pulso_botao.sv
`default_nettype none
// ============================================================================
//  Module      : pulso_botao
//  Description : Two-flop synchronizer followed by a registered rising-edge
//                detector. Emits one single-cycle pulse per 0->1 transition
//                of the raw button level, regardless of hold time.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulso_botao (
  input  logic clk,
  input  logic clr_n,
  input  logic in,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronize the raw level, then register a one-shot on its rising edge
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule
`default_nettype wire

// File: rtl/controlador_memoria.sv
`default_nettype none
// ============================================================================
//  Module      : controlador_memoria
//  Description : Push-button sequencer for a single-port synchronous RAM.
//                Turns four raw buttons into write / read / address-increment
//                / address-decrement commands and holds the last read word.
//  Revision    : 1.0 - initial release
// ============================================================================
module controlador_memoria
  import controlador_memoria_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              btn_wr,
  input  logic              btn_rd,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done
);

  logic [1:0] state;
  logic       p_wr;
  logic       p_rd;
  logic       p_inc;
  logic       p_dec;

  pulso_botao u_pulso_wr  (.clk(clk), .clr_n(clr_n), .in(btn_wr),  .pulse(p_wr));
  pulso_botao u_pulso_rd  (.clk(clk), .clr_n(clr_n), .in(btn_rd),  .pulse(p_rd));
  pulso_botao u_pulso_inc (.clk(clk), .clr_n(clr_n), .in(btn_inc), .pulse(p_inc));
  pulso_botao u_pulso_dec (.clk(clk), .clr_n(clr_n), .in(btn_dec), .pulse(p_dec));

  // Moore decodes straight from the state register so reset clears them at once
  assign mem_we = (state == ST_WRITE);
  assign busy   = (state != ST_IDLE);

  // Sequencer, address counter and data registers; commands only act in IDLE,
  // so pulses arriving while busy are simply dropped
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      mem_din  <= '0;
      dout     <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (p_wr) begin
            state   <= ST_WRITE;
            mem_din <= sw_data;
          end else if (p_rd) begin
            state <= ST_RD_ADDR;
          end else if (p_inc) begin
            mem_addr <= mem_addr + 1'b1;
          end else if (p_dec) begin
            mem_addr <= mem_addr - 1'b1;
          end
        end
        ST_WRITE: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        ST_RD_ADDR: begin
          // RAM registers the read on this edge; data is captured next cycle
          state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          dout  <= mem_q;
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controlador_memoria.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_controlador_memoria
//  Description : Self-checking bench for controlador_memoria with a RAM model
//                and a command-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_memoria;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk     = 1'b0;
  logic              clr_n   = 1'b0;
  logic              btn_wr  = 1'b0;
  logic              btn_rd  = 1'b0;
  logic              btn_inc = 1'b0;
  logic              btn_dec = 1'b0;
  logic [DATA_W-1:0] sw_data = '0;
  logic [DATA_W-1:0] mem_q   = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic [DATA_W-1:0] dout;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  // Physical RAM attached to the DUT
  logic [DATA_W-1:0] ram [DEPTH];

  // Command-level reference model
  int                model_addr = 0;
  logic [DATA_W-1:0] model_ram [DEPTH];
  logic [DATA_W-1:0] model_dout = '0;

  // Observation of write strobes and done pulses
  int                we_cnt   = 0;
  int                done_cnt = 0;
  logic [ADDR_W-1:0] we_addr  = '0;
  logic [DATA_W-1:0] we_din   = '0;

  always #5 clk = ~clk;

  controlador_memoria #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .btn_wr  (btn_wr),
    .btn_rd  (btn_rd),
    .btn_inc (btn_inc),
    .btn_dec (btn_dec),
    .sw_data (sw_data),
    .mem_q   (mem_q),
    .mem_addr(mem_addr),
    .mem_din (mem_din),
    .mem_we  (mem_we),
    .dout    (dout),
    .busy    (busy),
    .done    (done)
  );

  // Single-port synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_q <= ram[mem_addr];
  end

  // Count write strobes and done pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
      we_din  = mem_din;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_wr  = v;
      1: btn_rd  = v;
      2: btn_inc = v;
      default: btn_dec = v;
    endcase
  endtask

  // Press a button for 'hold' cycles, release it and let the command finish
  task automatic press(input int b, input int hold);
    set_btn(b, 1'b1);
    repeat (hold) tick();
    set_btn(b, 1'b0);
    repeat (8) tick();
  endtask

  // Reference effect of one accepted command: 0=write 1=read 2=inc 3=dec
  task automatic apply(input int b, input logic [DATA_W-1:0] d);
    case (b)
      0: model_ram[model_addr] = d;
      1: model_dout = model_ram[model_addr];
      2: model_addr = (model_addr + 1) % DEPTH;
      default: model_addr = (model_addr + DEPTH - 1) % DEPTH;
    endcase
  endtask

  task automatic goto_addr(input int target);
    for (int k = 0; k < DEPTH && model_addr != target; k++) begin
      press(2, 1);
      apply(2, '0);
    end
  endtask

  task automatic test_reset();
    int n;
    int d0;
    int w0;
    repeat (3) tick();
    checks++;
    if (mem_addr !== '0 || dout !== '0 || mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got addr=%0h dout=%0h we=%0b busy=%0b done=%0b required all 0",
               mem_addr, dout, mem_we, busy, done);
    end
    clr_n = 1'b1;
    tick();
    // Leave a nonzero word in dout and a nonzero address before the reset
    sw_data = 8'($urandom_range(1, 255));
    press(0, 2); apply(0, sw_data);
    press(1, 2); apply(1, '0);
    press(2, 1); apply(2, '0);
    checks++;
    if (dout !== model_dout) begin
      errors++;
      $display("FAIL pre_reset_read: got %0h required %0h", dout, model_dout);
    end
    sw_data = 8'($urandom);
    btn_wr = 1'b1;
    n = 0;
    while (mem_we !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait_we: got mem_we=%0b required 1 within 10 cycles", mem_we);
    end
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== '0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_mid_write: got we=%0b busy=%0b addr=%0h dout=%0h required 0 0 0 0",
               mem_we, busy, mem_addr, dout);
    end
    btn_wr = 1'b0;
    tick();
    tick();
    clr_n = 1'b1;
    model_addr = 0;
    model_dout = '0;
    d0 = done_cnt;
    w0 = we_cnt;
    repeat (10) tick();
    checks++;
    if (done_cnt !== d0 || we_cnt !== w0) begin
      errors++;
      $display("FAIL reset_no_done: got done=%0d we=%0d extra pulses required 0",
               done_cnt - d0, we_cnt - w0);
    end
  endtask

  task automatic test_write_read();
    int w0;
    sw_data = 8'hA5;
    w0 = we_cnt;
    btn_wr = 1'b1;
    repeat (3) tick();
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL wr_early: got mem_we=%0b after E2 required 0", mem_we);
    end
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_din !== 8'hA5 || mem_addr !== 4'(model_addr) || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_latency: got we=%0b din=%0h addr=%0h busy=%0b required 1 a5 %0h 1",
               mem_we, mem_din, mem_addr, busy, model_addr);
    end
    tick();
    checks++;
    if (mem_we !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL wr_done: got we=%0b done=%0b required 0 1", mem_we, done);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL wr_done_width: got done=%0b required 0", done);
    end
    btn_wr = 1'b0;
    repeat (8) tick();
    checks++;
    if (we_cnt !== w0 + 1) begin
      errors++;
      $display("FAIL wr_single_we: got %0d write cycles required 1", we_cnt - w0);
    end
    apply(0, 8'hA5);
    btn_rd = 1'b1;
    repeat (5) tick();
    checks++;
    if (dout !== model_dout || busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_before_e5: got dout=%0h busy=%0b required %0h 1", dout, busy, model_dout);
    end
    tick();
    apply(1, '0);
    checks++;
    if (dout !== 8'hA5 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_at_e5: got dout=%0h done=%0b busy=%0b required a5 1 0", dout, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rd_done_width: got done=%0b required 0", done);
    end
    btn_rd = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_held_inc();
    btn_inc = 1'b1;
    repeat (20) tick();
    btn_inc = 1'b0;
    repeat (6) tick();
    apply(2, '0);
    checks++;
    if (mem_addr !== 4'(model_addr)) begin
      errors++;
      $display("FAIL held_inc: got addr=%0h required %0h", mem_addr, model_addr);
    end
    for (int i = 0; i < 15; i++) begin
      press(2, $urandom_range(1, 6));
      apply(2, '0);
    end
    checks++;
    if (mem_addr !== 4'(model_addr) || mem_addr !== 4'h0) begin
      errors++;
      $display("FAIL inc_wrap: got addr=%0h required %0h", mem_addr, model_addr);
    end
    press(3, $urandom_range(1, 6));
    apply(3, '0);
    checks++;
    if (mem_addr !== 4'hF) begin
      errors++;
      $display("FAIL dec_wrap: got addr=%0h required f", mem_addr);
    end
  endtask

  task automatic test_simultaneous();
    int w0;
    logic [DATA_W-1:0] d;
    d = 8'($urandom);
    sw_data = d;
    w0 = we_cnt;
    btn_wr  = 1'b1;
    btn_inc = 1'b1;
    repeat (3) tick();
    btn_wr  = 1'b0;
    btn_inc = 1'b0;
    repeat (8) tick();
    apply(0, d);
    checks++;
    if (we_cnt !== w0 + 1 || we_addr !== 4'(model_addr) || we_din !== d || mem_addr !== 4'(model_addr)) begin
      errors++;
      $display("FAIL simultaneous: got we=%0d waddr=%0h wdin=%0h addr=%0h required 1 %0h %0h %0h",
               we_cnt - w0, we_addr, we_din, mem_addr, model_addr, d, model_addr);
    end
    press(1, 2);
    apply(1, '0);
    checks++;
    if (dout !== model_dout) begin
      errors++;
      $display("FAIL simultaneous_readback: got %0h required %0h", dout, model_dout);
    end
  endtask

  task automatic test_busy_drop();
    int d0;
    d0 = done_cnt;
    btn_rd = 1'b1;
    tick();
    btn_inc = 1'b1;
    repeat (3) tick();
    btn_rd  = 1'b0;
    btn_inc = 1'b0;
    repeat (8) tick();
    apply(1, '0);
    checks++;
    if (mem_addr !== 4'(model_addr) || dout !== model_dout || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL busy_drop: got addr=%0h dout=%0h done=%0d required %0h %0h 1",
               mem_addr, dout, done_cnt - d0, model_addr, model_dout);
    end
  endtask

  task automatic test_random();
    int b;
    int w0;
    int d0;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 24; i++) begin
      b = $urandom_range(0, 3);
      d = 8'($urandom);
      sw_data = d;
      w0 = we_cnt;
      d0 = done_cnt;
      press(b, $urandom_range(1, 5));
      apply(b, d);
      checks++;
      if (mem_addr !== 4'(model_addr) || dout !== model_dout) begin
        errors++;
        $display("FAIL random_%0d cmd=%0d: got addr=%0h dout=%0h required %0h %0h",
                 i, b, mem_addr, dout, model_addr, model_dout);
      end
      checks++;
      if (we_cnt - w0 !== ((b == 0) ? 1 : 0) || done_cnt - d0 !== ((b <= 1) ? 1 : 0)) begin
        errors++;
        $display("FAIL random_pulses_%0d cmd=%0d: got we=%0d done=%0d required %0d %0d",
                 i, b, we_cnt - w0, done_cnt - d0, (b == 0) ? 1 : 0, (b <= 1) ? 1 : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    int d0;
    goto_addr(2);
    w0 = we_cnt;
    d0 = done_cnt;
    sw_data = 8'h3C; press(0, 2); apply(0, 8'h3C);
    press(2, 1); apply(2, '0);
    sw_data = 8'hC3; press(0, 2); apply(0, 8'hC3);
    press(3, 1); apply(3, '0);
    press(1, 2); apply(1, '0);
    checks++;
    if (dout !== 8'h3C || mem_addr !== 4'h2) begin
      errors++;
      $display("FAIL b2b_first: got dout=%0h addr=%0h required 3c 2", dout, mem_addr);
    end
    press(2, 1); apply(2, '0);
    press(1, 2); apply(1, '0);
    checks++;
    if (dout !== 8'hC3 || dout !== model_dout) begin
      errors++;
      $display("FAIL b2b_second: got dout=%0h required c3", dout);
    end
    checks++;
    if (we_cnt - w0 !== 2 || done_cnt - d0 !== 4) begin
      errors++;
      $display("FAIL b2b_pulses: got we=%0d done=%0d required 2 4", we_cnt - w0, done_cnt - d0);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]       = '0;
      model_ram[i] = '0;
    end
    test_reset();
    test_write_read();
    test_held_inc();
    test_simultaneous();
    test_busy_drop();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
